rc_pwm_multi_decoder: RTL
=========================

// Module: rc_pwm_multi_decoder
// PURPOSE
// - Measures the high time of NUM_CH RC-receiver PWM channels (50 Hz frames, 1-2 ms pulses).
// - Reports each as an offset-removed, saturated count with a per-channel update strobe.
// - Replaces the single-channel reader; adds input sync, glitch/overrun rejection, loss-of-signal failsafe.
// - Sits between the receiver pins and the flight-control input mapper.
// PARAMETERS
// NUM_CH      6      number of independent PWM inputs
// OUT_W       10     width of each decoded value
// DIV         133    sys_clk cycles per sample tick (~400 ticks/ms at 53.2 MHz)
// OFFSET      400    ticks subtracted from measured width (1.0 ms)
// MIN_PULSE   300    widths below this (ticks) are glitches and are discarded (0.75 ms)
// MAX_PULSE   1000   widths above this (ticks) are overruns and are discarded (2.5 ms)
// TIMEOUT     10000  ticks with no accepted pulse before failsafe (25 ms)
// FAILSAFE    0      value forced onto a channel's output on timeout
// PORTS
// sys_clk     in   1           system clock
// resetn      in   1           asynchronous active-low reset
// pwm_in      in   NUM_CH      raw receiver inputs, asynchronous to sys_clk
// pwm_out     out  NUM_CH*OUT_W  decoded values, ch i at [i*OUT_W +: OUT_W]
// pwm_valid   out  NUM_CH      1-cycle strobe when ch i's value updates
// ch_lost     out  NUM_CH      high while ch i is in failsafe
// err_pulse   out  NUM_CH      1-cycle strobe on a rejected (glitch or overrun) pulse
// BEHAVIOUR
// - One clock, sys_clk. Reset is asynchronous and active-low: resetn low clears all state immediately.
// - Reset values: pwm_out=FAILSAFE, pwm_valid=0, err_pulse=0, ch_lost=all 1s, prescaler=0,
//   every channel in ARM.
// - Each input passes through a 2-FF synchronizer before edge detection. Edges are seen 2-3 clocks late.
// - One shared prescaler counts 0..DIV-1. tick is high for one cycle when it wraps.
//   All channel counters advance only on tick.
// - Per-channel FSM (3 states):
//   ARM: wait for a synced low (discards the partial pulse after reset). low -> IDLE.
//   IDLE: width=0. Rising edge -> MEASURE.
//   MEASURE: width += 1 on tick, saturating at MAX_PULSE+1.
//     On falling edge -> IDLE, and:
//     MIN_PULSE <= width <= MAX_PULSE: accept.
//       pwm_out <= min(max(width-OFFSET,0), 2^OUT_W-1), pwm_valid=1, clear timeout, ch_lost<=0.
//     Otherwise: pwm_out holds its value, err_pulse=1, timeout is not cleared.
// - The subtraction uses width+1 bits. A negative result clamps to 0 (never wraps).
// - The accepted value is registered the cycle after the synced falling edge.
//   pwm_valid asserts in that same cycle.
// - Timeout counter per channel: increments on tick in every state, saturating at TIMEOUT.
//   Reaching TIMEOUT: pwm_out<=FAILSAFE, ch_lost<=1 (level).
//   pwm_valid pulses once on entry to failsafe.
// - Falling edge and timeout in the same cycle: accept wins, timeout clears, no failsafe.
// - Edge and tick in the same cycle: the edge is processed and that tick is counted in the old state.
// - A stuck-high input saturates width, then timeout forces failsafe. The next fall raises err_pulse.
// - Channels are fully independent. Simultaneous events on several channels all complete the same cycle.
// STRUCTURE
// - Package rc_pwm_pkg: FSM state encodings (ARM/IDLE/MEASURE), default OFFSET/MIN/MAX/TIMEOUT constants.
// - Sub-module rc_pwm_channel: synchronizer, FSM, width/timeout counters, output register.
//   Instanced NUM_CH times by a generate loop.
// - Top level holds only the prescaler and output bus packing.
// TESTING (bench overrides DIV=1 for speed unless noted)
// 1 Reset: hold pwm_in high through reset release, then 600-tick pulse.
//   -> first pulse ignored (ARM). Second 600-tick pulse -> pwm_out=200, pwm_valid 1 cycle, ch_lost=0.
// 2 Range: pulses of 400, 800 and 1000 ticks on ch0 -> 0, 400, 600. 350 ticks -> 0 (clamped).
// 3 Reject: 100-tick glitch -> err_pulse, value unchanged.
//   1200-tick pulse -> err_pulse, value unchanged, no pwm_valid.
// 4 Failsafe: last accepted 600, then input low for 10000 ticks.
//   -> ch_lost=1, pwm_out=FAILSAFE, one pwm_valid. Next 600-tick pulse restores 200 and ch_lost=0.
// 5 Multi-channel: NUM_CH=6, falling edges with widths 400..900 in the same cycle.
//   -> all six pwm_valid together, values 0,100,...,500.
// 6 Async reset: assert resetn mid-MEASURE -> outputs at reset values within the cycle. Re-arm works.
//   DIV=133 run: 1.5 ms pulse -> 200 +/-1.

Source files
------------

// File: rtl/rc_pwm_pkg.sv
// Shared FSM encoding and default timing constants for the RC PWM decoder.
// Tick-based constants assume ~400 ticks per millisecond.
package rc_pwm_pkg;

  typedef enum logic [1:0] {
    ST_ARM     = 2'd0,
    ST_IDLE    = 2'd1,
    ST_MEASURE = 2'd2
  } ch_state_e;

  localparam int DEF_NUM_CH    = 6;
  localparam int DEF_OUT_W     = 10;
  localparam int DEF_DIV       = 133;
  localparam int DEF_OFFSET    = 400;
  localparam int DEF_MIN_PULSE = 300;
  localparam int DEF_MAX_PULSE = 1000;
  localparam int DEF_TIMEOUT   = 10000;
  localparam int DEF_FAILSAFE  = 0;

endpackage

// File: rtl/rc_pwm_channel.sv
// One RC PWM input: synchronizer, ARM/IDLE/MEASURE FSM, width and loss-of-signal
// counters, and the registered offset-removed, saturated output value.
module rc_pwm_channel
  import rc_pwm_pkg::*;
#(
  parameter int OUT_W     = DEF_OUT_W,
  parameter int OFFSET    = DEF_OFFSET,
  parameter int MIN_PULSE = DEF_MIN_PULSE,
  parameter int MAX_PULSE = DEF_MAX_PULSE,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int FAILSAFE  = DEF_FAILSAFE
) (
  input  logic             sys_clk,
  input  logic             resetn,
  input  logic             tick,
  input  logic             pwm_in,
  output logic [OUT_W-1:0] pwm_out,
  output logic             pwm_valid,
  output logic             ch_lost,
  output logic             err_pulse
);

  localparam int WW      = $clog2(MAX_PULSE + 2);
  localparam int TW      = $clog2(TIMEOUT + 1);
  localparam int OUT_MAX = (1 << OUT_W) - 1;

  ch_state_e         state, state_nxt;
  logic              sync_p0, sync_p1, sync_p2;
  logic              rise, fall, accept, reject, tmo_hit;
  logic [WW-1:0]     width, width_nxt, width_cnt;
  logic [TW-1:0]     tmo, tmo_nxt;
  logic signed [WW:0] diff;

  function automatic logic [OUT_W-1:0] sat_out(input logic signed [WW:0] d);
    if (d[WW]) return '0;
    if (int'(d) > OUT_MAX) return '1;
    return OUT_W'(d);
  endfunction

  // Stage p0/p1: metastability filter; p2: previous synced level for edges.
  // Reset to high so a pulse already in progress at reset release is not
  // mistaken for a rising edge.
  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      sync_p2 <= 1'b1;
    end else begin
      sync_p0 <= pwm_in;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign rise = sync_p1 & ~sync_p2;
  assign fall = ~sync_p1 & sync_p2;

  // A tick coinciding with the falling edge still counts toward this pulse.
  assign width_cnt = (tick && width <= WW'(MAX_PULSE)) ? width + WW'(1) : width;
  assign diff      = $signed({1'b0, width_cnt}) - $signed((WW+1)'(OFFSET));

  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) state <= ST_ARM;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    width_nxt = width;
    accept    = 1'b0;
    reject    = 1'b0;
    case (state)
      ST_ARM: begin
        width_nxt = '0;
        if (!sync_p1) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        width_nxt = '0;
        if (rise) state_nxt = ST_MEASURE;
      end
      ST_MEASURE: begin
        width_nxt = width_cnt;
        if (fall) begin
          state_nxt = ST_IDLE;
          if (width_cnt >= WW'(MIN_PULSE) && width_cnt <= WW'(MAX_PULSE)) accept = 1'b1;
          else                                                          reject = 1'b1;
        end
      end
      default: state_nxt = ST_ARM;
    endcase
    tmo_nxt = accept ? '0 : ((tick && tmo != TW'(TIMEOUT)) ? tmo + TW'(1) : tmo);
    // Only a live channel strobes on entering failsafe; an accept this cycle wins.
    tmo_hit = !accept && !ch_lost && (tmo_nxt == TW'(TIMEOUT));
  end

  // Output stage: value and strobes land one cycle after the synced edge.
  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      width     <= '0;
      tmo       <= '0;
      pwm_out   <= OUT_W'(FAILSAFE);
      pwm_valid <= 1'b0;
      err_pulse <= 1'b0;
      ch_lost   <= 1'b1;
    end else begin
      width     <= width_nxt;
      tmo       <= tmo_nxt;
      pwm_valid <= accept | tmo_hit;
      err_pulse <= reject;
      if (accept) begin
        pwm_out <= sat_out(diff);
        ch_lost <= 1'b0;
      end else if (tmo_hit) begin
        pwm_out <= OUT_W'(FAILSAFE);
        ch_lost <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/rc_pwm_multi_decoder.sv
// Multi-channel RC PWM decoder: shared sample-tick prescaler feeding NUM_CH
// independent channel decoders, with their outputs packed onto flat buses.
module rc_pwm_multi_decoder
  import rc_pwm_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int OUT_W     = DEF_OUT_W,
  parameter int DIV       = DEF_DIV,
  parameter int OFFSET    = DEF_OFFSET,
  parameter int MIN_PULSE = DEF_MIN_PULSE,
  parameter int MAX_PULSE = DEF_MAX_PULSE,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int FAILSAFE  = DEF_FAILSAFE
) (
  input  logic                    sys_clk,
  input  logic                    resetn,
  input  logic [NUM_CH-1:0]       pwm_in,
  output logic [NUM_CH*OUT_W-1:0] pwm_out,
  output logic [NUM_CH-1:0]       pwm_valid,
  output logic [NUM_CH-1:0]       ch_lost,
  output logic [NUM_CH-1:0]       err_pulse
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] presc;
  logic          tick;

  assign tick = (presc == PW'(DIV - 1));

  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) presc <= '0;
    else         presc <= tick ? '0 : presc + PW'(1);
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    rc_pwm_channel #(
      .OUT_W     (OUT_W),
      .OFFSET    (OFFSET),
      .MIN_PULSE (MIN_PULSE),
      .MAX_PULSE (MAX_PULSE),
      .TIMEOUT   (TIMEOUT),
      .FAILSAFE  (FAILSAFE)
    ) u_ch (
      .sys_clk   (sys_clk),
      .resetn    (resetn),
      .tick      (tick),
      .pwm_in    (pwm_in[i]),
      .pwm_out   (pwm_out[i*OUT_W +: OUT_W]),
      .pwm_valid (pwm_valid[i]),
      .ch_lost   (ch_lost[i]),
      .err_pulse (err_pulse[i])
    );
  end

endmodule
